lza_serial_normalizer: RTL and testbench

- Multi-cycle post-addition normalizer for the FPU datapath.
- Consumes the raw mantissa sum produced by the ripple/PG adder chain and finds its leading-zero count.
- Left-shifts the mantissa until the MSB is 1 and decrements the exponent by the shift amount.
- Iterative, shift-by-COARSE or shift-by-1 per cycle, with a start/ready/valid handshake. Trades latency for area versus a full-width LZA plus barrel shifter.

---
 rtl/lza_serial_normalizer_if.sv | 28 ++
 rtl/lza_serial_normalizer.sv | 123 ++++++++++++
 tb/tb_lza_serial_normalizer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lza_serial_normalizer_if.sv
// Handshake and data bundle for the serial post-addition normalizer.
// The master issues a mantissa/exponent pair; the slave returns the normalized result.
interface lza_serial_normalizer_if #(
  parameter int W  = 24,
  parameter int EW = 8,
  parameter int SW = $clog2(W + 1)
);
  logic          start_i;
  logic [W-1:0]  Sum_i;
  logic [EW-1:0] Exp_i;
  logic          ready_o;
  logic          valid_o;
  logic [W-1:0]  Mant_o;
  logic [EW-1:0] Exp_o;
  logic [SW-1:0] Shamt_o;
  logic          zero_o;
  logic          unf_o;

  modport master (
    output start_i, Sum_i, Exp_i,
    input  ready_o, valid_o, Mant_o, Exp_o, Shamt_o, zero_o, unf_o
  );

  modport slave (
    input  start_i, Sum_i, Exp_i,
    output ready_o, valid_o, Mant_o, Exp_o, Shamt_o, zero_o, unf_o
  );
endinterface

// File: rtl/lza_serial_normalizer.sv
// Iterative normalizer: strips leading zeros COARSE bits or one bit per cycle,
// then reports the normalized mantissa, shift count and adjusted exponent.
module lza_serial_normalizer #(
  parameter int W      = 24,
  parameter int EW     = 8,
  parameter int COARSE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lza_serial_normalizer_if.slave   bus
);

  localparam int SW = $clog2(W + 1);
  // Wide enough to hold either operand plus a borrow bit.
  localparam int DW = ((EW > SW) ? EW : SW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  mreg;
  logic [EW-1:0] ereg;
  logic [SW-1:0] cnt;

  logic          valid_q;
  logic [W-1:0]  mant_q;
  logic [EW-1:0] exp_q;
  logic [SW-1:0] shamt_q;
  logic          zero_q;
  logic          unf_q;

  logic [DW-1:0] exp_ext;
  logic [DW-1:0] cnt_ext;
  logic [DW-1:0] exp_diff;
  logic          exp_borrow;
  logic          top_zero;

  // Borrow out of the zero-extended subtraction means cnt > ereg.
  always_comb begin
    exp_ext    = DW'(ereg);
    cnt_ext    = DW'(cnt);
    exp_diff   = exp_ext - cnt_ext;
    exp_borrow = exp_diff[DW-1];
    top_zero   = (mreg[W-1 -: COARSE] == '0);
  end

  // NOTE: every register here is updated with <= so that all reads in this
  // block see the pre-edge values, exactly like the hardware flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mreg    <= '0;
      ereg    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mreg <= bus.Sum_i;
            ereg <= bus.Exp_i;
            cnt  <= '0;
            if (bus.Sum_i == '0) begin
              state   <= DONE;
              valid_q <= 1'b1;
              mant_q  <= '0;
              shamt_q <= SW'(W);
              exp_q   <= '0;
              zero_q  <= 1'b1;
              unf_q   <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (mreg[W-1]) begin
            state   <= DONE;
            valid_q <= 1'b1;
            mant_q  <= mreg;
            shamt_q <= cnt;
            zero_q  <= 1'b0;
            unf_q   <= exp_borrow;
            exp_q   <= exp_borrow ? '0 : exp_diff[EW-1:0];
          end else if (top_zero) begin
            mreg <= mreg << COARSE;
            cnt  <= cnt + SW'(COARSE);
          end else begin
            mreg <= mreg << 1;
            cnt  <= cnt + SW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = valid_q;
  assign bus.Mant_o  = mant_q;
  assign bus.Exp_o   = exp_q;
  assign bus.Shamt_o = shamt_q;
  assign bus.zero_o  = zero_q;
  assign bus.unf_o   = unf_q;

endmodule

// File: tb/tb_lza_serial_normalizer.sv
// Directed bench for lza_serial_normalizer: vector table for single requests,
// hand-written sequences for back-to-back starts and reset during SHIFT.
module tb_lza_serial_normalizer;

  localparam int W  = 24;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lza_serial_normalizer_if #(.W(W), .EW(EW)) bus ();

  lza_serial_normalizer #(.W(W), .EW(EW), .COARSE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  sum;
    logic [EW-1:0] ein;
    logic [W-1:0]  mant;
    int            shamt;
    logic [EW-1:0] eout;
    logic          zero;
    logic          unf;
    int            lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc;
    bit got;
    bit rdy_low;
    cyc     = 0;
    got     = 1'b0;
    rdy_low = 1'b1;
    check($sformatf("v%0d ready_idle", idx), 32'(bus.ready_o), 32'd1);
    bus.start_i = 1'b1;
    bus.Sum_i   = v.sum;
    bus.Exp_i   = v.ein;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.start_i = 1'b0;
        bus.Sum_i   = W'($urandom);
        bus.Exp_i   = EW'($urandom);
      end
      if (bus.valid_o) got = 1'b1;
      if (bus.ready_o) rdy_low = 1'b0;
    end
    check($sformatf("v%0d valid_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d ready_busy", idx), 32'(rdy_low), 32'd1);
    check($sformatf("v%0d mant", idx), 32'(bus.Mant_o), 32'(v.mant));
    check($sformatf("v%0d shamt", idx), 32'(bus.Shamt_o), 32'(v.shamt));
    check($sformatf("v%0d exp", idx), 32'(bus.Exp_o), 32'(v.eout));
    check($sformatf("v%0d zero", idx), 32'(bus.zero_o), 32'(v.zero));
    check($sformatf("v%0d unf", idx), 32'(bus.unf_o), 32'(v.unf));
    tick();
    check($sformatf("v%0d valid_drop", idx), 32'(bus.valid_o), 32'd0);
    check($sformatf("v%0d mant_hold", idx), 32'(bus.Mant_o), 32'(v.mant));
  endtask

  initial begin
    int pulses;
    int first_cyc;
    int second_cyc;
    int sh1;
    int sh2;
    int e1;

    //          sum        ein   mant       sh  eout  z  u  lat
    vecs[0] = '{24'h800000, 8'd10,  24'h800000, 0,  8'd10,  0, 0, 2};
    vecs[1] = '{24'h000001, 8'd100, 24'h800000, 23, 8'd77,  0, 0, 10};
    vecs[2] = '{24'h000000, 8'd5,   24'h000000, 24, 8'd0,   1, 0, 1};
    vecs[3] = '{24'h003000, 8'd7,   24'hC00000, 10, 8'd0,   0, 1, 6};
    vecs[4] = '{24'h0F0000, 8'd20,  24'hF00000, 4,  8'd16,  0, 0, 3};
    vecs[5] = '{24'h123456, 8'd3,   24'h91A2B0, 3,  8'd0,   0, 0, 5};
    vecs[6] = '{24'h000100, 8'd255, 24'h800000, 15, 8'd240, 0, 0, 8};
    vecs[7] = '{24'h7FFFFF, 8'd0,   24'hFFFFFE, 1,  8'd0,   0, 1, 3};
    vecs[8] = '{24'h000010, 8'd19,  24'h800000, 19, 8'd0,   0, 0, 9};

    bus.start_i = 1'b0;
    bus.Sum_i   = '0;
    bus.Exp_i   = '0;
    rst_n       = 1'b0;

    #12;
    check("rst ready", 32'(bus.ready_o), 32'd1);
    check("rst valid", 32'(bus.valid_o), 32'd0);
    check("rst mant", 32'(bus.Mant_o), 32'd0);
    check("rst shamt", 32'(bus.Shamt_o), 32'd0);
    check("rst exp", 32'(bus.Exp_o), 32'd0);
    check("rst zero_unf", 32'({bus.zero_o, bus.unf_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run(vecs[i], i);

    // Back-to-back: start held high; requests during SHIFT/DONE must be dropped.
    pulses     = 0;
    first_cyc  = -1;
    second_cyc = -1;
    sh1 = -1;
    sh2 = -1;
    e1  = -1;
    bus.start_i = 1'b1;
    bus.Sum_i   = 24'h400000;
    bus.Exp_i   = 8'd50;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) begin
        bus.Sum_i = 24'h200000;
        bus.Exp_i = 8'd60;
      end
      if (cyc == 4) check("b2b ready_between", 32'(bus.ready_o), 32'd1);
      if (cyc == 9) bus.start_i = 1'b0;
      if (bus.valid_o) begin
        pulses++;
        if (pulses == 1) begin
          first_cyc = cyc;
          sh1 = int'(bus.Shamt_o);
          e1  = int'(bus.Exp_o);
        end else if (pulses == 2) begin
          second_cyc = cyc;
          sh2 = int'(bus.Shamt_o);
        end
      end
    end
    check("b2b pulses", 32'(pulses), 32'd2);
    check("b2b first_cycle", 32'(first_cyc), 32'd3);
    check("b2b second_cycle", 32'(second_cyc), 32'd8);
    check("b2b shamt1", 32'(sh1), 32'd1);
    check("b2b exp1", 32'(e1), 32'd49);
    check("b2b shamt2", 32'(sh2), 32'd2);
    check("b2b mant2", 32'(bus.Mant_o), 32'h800000);

    // Reset while SHIFT is in progress: outputs clear at once, no pulse follows.
    bus.start_i = 1'b1;
    bus.Sum_i   = 24'h000001;
    bus.Exp_i   = 8'd100;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      if (cyc == 1) bus.start_i = 1'b0;
    end
    check("mid ready_busy", 32'(bus.ready_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst mant", 32'(bus.Mant_o), 32'd0);
    check("mid rst shamt", 32'(bus.Shamt_o), 32'd0);
    check("mid rst exp", 32'(bus.Exp_o), 32'd0);
    check("mid rst ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      if (bus.valid_o) pulses++;
    end
    check("mid no_valid", 32'(pulses), 32'd0);
    check("mid ready_after", 32'(bus.ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
